// File: rtl/lif_layer_scheduler.sv
// lif_layer_scheduler: time-multiplexed Q8.8 LIF neuron sweep over one shared datapath
// Ports: clk/rst (sync, active-high); start+dt_tau begin a sweep; cur_req/cur_addr/cur_valid/cur_data
// fetch per-neuron current; spike_valid/spike_idx/spike_ready emit spikes; busy/done report sweep
// progress; v_mon_idx/v_mon give a combinational debug read of the membrane array.
module lif_layer_scheduler #(
  parameter int N_NEURONS = 8,
  parameter int IDX_W = 3,
  parameter logic signed [15:0] THRESHOLD = 16'sh3200,
  parameter logic signed [15:0] V_RESET = 16'sh0000,
  parameter int REFRAC_STEPS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [15:0] dt_tau,
  output logic cur_req,
  output logic [IDX_W-1:0] cur_addr,
  input  logic cur_valid,
  input  logic [15:0] cur_data,
  output logic spike_valid,
  output logic [IDX_W-1:0] spike_idx,
  input  logic spike_ready,
  output logic busy,
  output logic done,
  input  logic [IDX_W-1:0] v_mon_idx,
  output logic [15:0] v_mon
);
  localparam int RW = REFRAC_STEPS > 0 ? $clog2(REFRAC_STEPS + 1) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, COMPUTE, WRITE, EMIT, DONE} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx;
  logic signed [15:0] dt_q, cur_q, vnew_q, v_cur, delta, prod, v_new;
  logic signed [31:0] prod_full;
  logic signed [15:0] v_mem [N_NEURONS];
  logic [RW-1:0] refrac [N_NEURONS];
  logic last, refr, fire, advance;
  function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
    return x > 32767 ? 16'sh7FFF : x < -32768 ? 16'sh8000 : x[15:0];
  endfunction
  always_comb begin
    v_cur = v_mem[idx];
    delta = sat16(32'(cur_q) - 32'(v_cur));
    prod_full = 32'(delta) * 32'(dt_q);
    prod = sat16(prod_full >>> 8);
    v_new = sat16(32'(v_cur) + 32'(prod));
  end
  assign last = idx == IDX_W'(N_NEURONS - 1);
  assign refr = refrac[idx] != '0;
  // A refractory neuron is clamped to V_RESET and cannot fire regardless of v_new.
  assign fire = !refr && vnew_q >= THRESHOLD;
  assign advance = (state_q == WRITE && !fire) || (state_q == EMIT && spike_ready);
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? FETCH : IDLE;
      FETCH:   state_d = cur_valid ? COMPUTE : FETCH;
      COMPUTE: state_d = WRITE;
      WRITE:   state_d = fire ? EMIT : last ? DONE : FETCH;
      EMIT:    state_d = !spike_ready ? EMIT : last ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      dt_q <= '0;
      cur_q <= '0;
      vnew_q <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v_mem[i] <= '0;
        refrac[i] <= '0;
      end
    end else begin
      if (state_q == IDLE && start) begin
        dt_q <= dt_tau;
        idx <= '0;
      end
      if (state_q == FETCH && cur_valid) cur_q <= cur_data;
      if (state_q == COMPUTE) vnew_q <= v_new;
      if (state_q == WRITE) begin
        v_mem[idx] <= refr || fire ? V_RESET : vnew_q;
        refrac[idx] <= refr ? refrac[idx] - RW'(1) : fire ? RW'(REFRAC_STEPS) : refrac[idx];
      end
      if (advance && !last) idx <= idx + IDX_W'(1);
      if (state_q == DONE) idx <= '0;
    end
  end
  assign cur_req = state_q == FETCH;
  assign cur_addr = idx;
  assign spike_valid = state_q == EMIT;
  assign spike_idx = idx;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign v_mon = v_mem[v_mon_idx];
endmodule

// File: tb/tb_lif_layer_scheduler.sv
// tb_lif_layer_scheduler: scoreboard bench for lif_layer_scheduler with directed sweeps
module tb_lif_layer_scheduler;
  logic clk = 0, rst = 1, start = 0, spike_ready = 1, cv_en = 1;
  logic [15:0] dt_tau = 16'h0080;
  logic [15:0] cur_data, v_mon;
  logic [2:0] cur_addr, spike_idx;
  logic [2:0] v_mon_idx = 0;
  logic cur_req, cur_valid, spike_valid, busy, done;
  logic [15:0] cur_tab [8];
  logic [2:0] exp_q [$];
  int checks = 0, errors = 0, cyc = 0, t0;
  assign cur_valid = cv_en;
  assign cur_data = cur_tab[cur_addr];
  lif_layer_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .dt_tau(dt_tau),
    .cur_req(cur_req), .cur_addr(cur_addr), .cur_valid(cur_valid), .cur_data(cur_data),
    .spike_valid(spike_valid), .spike_idx(spike_idx), .spike_ready(spike_ready),
    .busy(busy), .done(done), .v_mon_idx(v_mon_idx), .v_mon(v_mon)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    #2;
    if (!rst && spike_valid) begin
      chk("no_req_in_emit", 32'(cur_req), 32'(0));
      if (spike_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_spike got idx %0d want none", spike_idx);
        end else chk("spike_idx", 32'(spike_idx), 32'(exp_q.pop_front()));
      end
    end
  end
  task automatic set_cur(input int n, input logic [15:0] val);
    for (int i = 0; i < 8; i++) cur_tab[i] = 16'h0000;
    cur_tab[n] = val;
  endtask
  task automatic chk_v(input int n, input logic [15:0] e);
    v_mon_idx = 3'(n);
    #1;
    chk($sformatf("v_mon[%0d]", n), 32'(v_mon), 32'(e));
  endtask
  task automatic chk_all(input logic [15:0] e);
    for (int i = 0; i < 8; i++) chk_v(i, e);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask
  task automatic start_sweep(output int t);
    @(negedge clk);
    start = 1;
    t = cyc;
    @(negedge clk);
    start = 0;
    chk("first_fetch", 32'({cur_req, cur_addr}), 32'h8);
  endtask
  task automatic wait_done(input int t, input int exp_lat);
    int n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got busy %0b want done", busy);
    end else if (exp_lat > 0) chk("latency", 32'(cyc - t), 32'(exp_lat));
    @(negedge clk);
    chk("done_pulse", 32'({done, busy}), 32'h0);
    chk("sb_empty", 32'(exp_q.size()), 32'(0));
  endtask
  task automatic sweep(input int exp_lat);
    int t;
    start_sweep(t);
    wait_done(t, exp_lat);
  endtask
  task automatic wait_fetch(input logic [2:0] n);
    int k = 0;
    while (!(cur_req && cur_addr == n) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("reach_fetch", 32'(cur_addr), 32'(n));
  endtask
  initial begin
    set_cur(0, 16'h0000);
    repeat (3) @(negedge clk);
    rst = 0;
    chk("reset_outputs", 32'({busy, done, spike_valid, cur_req, cur_addr, spike_idx}), 32'h0);
    chk_all(16'h0000);
    for (int i = 0; i < 8; i++) cur_tab[i] = 16'h2000;
    start_sweep(t0);
    wait_fetch(3);
    cv_en = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("abort_busy_done", 32'({busy, done, spike_valid}), 32'h0);
    rst = 0;
    cv_en = 1;
    chk_all(16'h0000);
    sweep(25);
    chk_all(16'h1000);
    sweep(25);
    chk_all(16'h1800);
    do_reset();
    set_cur(5, 16'h6400);
    spike_ready = 0;
    exp_q.push_back(3'd5);
    start_sweep(t0);
    for (int k = 0; k < 200 && !spike_valid; k++) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("bp_hold%0d", k), 32'({spike_valid, cur_req, spike_idx}), 32'h15);
      @(negedge clk);
    end
    spike_ready = 1;
    wait_done(t0, 0);
    chk_v(5, 16'h0000);
    sweep(25);
    chk_v(5, 16'h0000);
    sweep(25);
    chk_v(5, 16'h0000);
    exp_q.push_back(3'd5);
    sweep(26);
    chk_v(5, 16'h0000);
    do_reset();
    dt_tau = 16'h0400;
    set_cur(1, 16'h7F00);
    exp_q.push_back(3'd1);
    sweep(26);
    chk_v(1, 16'h0000);
    do_reset();
    dt_tau = 16'h0080;
    set_cur(3, 16'h6200);
    sweep(25);
    chk_v(3, 16'h3100);
    dt_tau = 16'h0400;
    set_cur(3, 16'h8000);
    sweep(25);
    chk_v(3, 16'hB100);
    sweep(25);
    chk_v(3, 16'h8000);
    do_reset();
    dt_tau = 16'h0080;
    set_cur(2, 16'h2000);
    start_sweep(t0);
    wait_fetch(2);
    cv_en = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d", k), 32'({busy, cur_req, cur_addr}), 32'h1A);
      if (k == 4) begin
        start = 1;
        dt_tau = 16'h0400;
      end
      if (k == 5) start = 0;
    end
    cv_en = 1;
    wait_done(t0, 0);
    chk_v(2, 16'h1000);
    repeat (3) @(negedge clk);
    chk("idle_after_stall", 32'(busy), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lif_layer_scheduler.md
Name: lif_layer_scheduler

Overview:
Time-multiplexed controller that steps N_NEURONS Q8.8 leaky integrate-and-fire neurons through one shared LIF update datapath. The block holds the membrane potential and refractory state of every neuron. It fetches each neuron's input current over a request/valid interface and emits spike events over a valid/ready handshake. It sits between the synaptic current accumulator (upstream) and the spike router (downstream), with one sweep over all neurons per simulation timestep.

Parameters:
N_NEURONS, 8, number of neurons sequenced per timestep (>=2)
IDX_W, 3, width of neuron index, equal to ceil(log2(N_NEURONS))
THRESHOLD, 16'h3200, spike threshold in Q8.8 (50.0)
V_RESET, 16'h0000, post-spike membrane value in Q8.8
REFRAC_STEPS, 2, timesteps a neuron is held at V_RESET after spiking (0 = none)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin one timestep sweep; sampled only in IDLE
dt_tau  input  16  Q8.8 dt/tau; latched on accepted start
cur_req  output  1  request current for neuron cur_addr
cur_addr  output  IDX_W  neuron index being fetched
cur_valid  input  1  cur_data valid; consumed only while cur_req=1
cur_data  input  16  signed Q8.8 input current
spike_valid  output  1  spike event pending
spike_idx  output  IDX_W  index of spiking neuron
spike_ready  input  1  downstream accepts the spike event
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at end of sweep
v_mon_idx  input  IDX_W  debug read index
v_mon  output  16  membrane potential of neuron v_mon_idx, combinational read

Behaviour:
- The block has the following states: IDLE, FETCH, COMPUTE, WRITE, EMIT, DONE. The neuron index idx resets to 0.
- Reset values: all outputs are 0. All membrane entries are 0, all refractory counters are 0, idx is 0, and the state is IDLE. Asserting rst in any state aborts the sweep on the next edge with no done pulse and no spike.
- IDLE: if start=1, latch dt_tau, set idx=0, and go to FETCH. A start pulse outside IDLE is ignored.
- FETCH: cur_req=1 and cur_addr=idx. On a cycle where cur_valid=1, register cur_data and go to COMPUTE. Otherwise stay in FETCH indefinitely.
- COMPUTE: register the result of one datapath evaluation.
  - delta = sat16(I - V), computed at 17 bits and clamped to [0x8000, 0x7FFF].
  - prod = sat16((delta * dt_tau) >>> 8), using a 32-bit signed product with an arithmetic shift; the result is clamped the same way.
  - v_new = sat16(V + prod).
- WRITE, refractory neuron (refrac[idx] != 0): decrement refrac[idx], write V_RESET, and raise no spike. The current value has still been consumed.
- WRITE, otherwise, if v_new >= THRESHOLD (signed compare on the new value): write V_RESET, load refrac[idx]=REFRAC_STEPS, and go to EMIT.
- WRITE, otherwise (below threshold): write v_new.
- WRITE, no spike: if idx == N_NEURONS-1, go to DONE; else idx++ and go to FETCH.
- EMIT: spike_valid=1 and spike_idx=idx, held stable until the cycle where spike_ready=1. Then advance exactly as WRITE does without a spike. spike_valid is never asserted in any other state.
- DONE: done=1 for exactly one cycle, then IDLE with idx=0.
- Latency: with cur_valid tied high and no spikes, start sampled at cycle t gives done=1 at cycle t+1+3*N_NEURONS. Each spike adds at least 1 cycle.
- Membrane and refractory state persist across sweeps. They change only in WRITE, or on rst.
- v_mon reads the stored array. A write in WRITE becomes visible on the next cycle.

Test Plan:
- Reset: assert rst mid-FETCH of neuron 3. All v_mon read 0x0000, busy=0, no done pulse. A new start then sweeps from idx 0.
- Sub-threshold integration: dt_tau=0x0080 (0.5) and I=0x2000 for all neurons, two sweeps. After sweep 1, v_mon=0x1000. After sweep 2, v_mon=0x1800. No spikes. done occurs at t+25 for N=8.
- Spike with back-pressure: dt_tau=0x0080, I=0x6400 for neuron 5 only.
  - v_new=0x3200 produces spike_valid with spike_idx=5.
  - Hold spike_ready=0 for 4 cycles: spike_valid and spike_idx stay stable and cur_req stays 0.
  - After accept, v_mon[5]=0x0000.
- Refractory (REFRAC_STEPS=2): keep I=0x6400 on neuron 5. It spikes in sweep 1, is silent at V=0 in sweeps 2 and 3, and spikes again in sweep 4.
- Saturation: dt_tau=0x0400 (4.0) and I=0x7F00 with V=0. prod clamps to 0x7FFF, then a spike occurs. Separately, I=0x8000 with V=0x3100 gives delta clamped to 0x8000 and v_mon never wraps positive.
- Stall and ignored start: hold cur_valid=0 for 10 cycles on neuron 2 while pulsing start. The FSM stays in FETCH with cur_addr=2, and the extra start pulse has no effect.
